// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - CSR-fed word FIFO drained by an 8N1 UART transmitter
module uart_tx_fifo #(
    parameter int          DEPTH    = 8,
    parameter logic [11:0] CSR_ADDR = 12'h050
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        csr_enable,
    input  logic [11:0] csr_addr,
    input  logic [2:0]  csr_op,
    input  logic [4:0]  rs1_zimm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] prescaler,
    output logic [31:0] csr_data_out,
    output logic        tx,
    output logic        have_next,
    output logic        busy
);

    // RISC-V funct3 encodings of the CSR instructions
    localparam logic [2:0] OP_RW  = 3'b001;
    localparam logic [2:0] OP_RWI = 3'b101;

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    state_t           state_q;
    logic [31:0]      word_q;
    logic [1:0]       byte_idx_q;
    logic [2:0]       bit_idx_q;
    logic [31:0]      cnt_q;
    logic             tx_q;

    logic             csr_hit;
    logic             push_req;
    logic             push_ok;
    logic             pop_ok;
    logic             full;
    logic [31:0]      push_data;
    logic [2:0]       next_bit;

    assign csr_hit   = csr_enable && (csr_addr == CSR_ADDR);
    assign push_req  = csr_hit && ((csr_op == OP_RW) || (csr_op == OP_RWI));
    assign push_data = (csr_op == OP_RWI) ? {27'b0, rs1_zimm} : rs1_data;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign have_next = (count_q != '0);
    // The transmitter takes the head word in the single IDLE cycle it leaves from
    assign pop_ok    = (state_q == IDLE) && have_next;
    // A full FIFO still accepts a push when the same cycle pops the head
    assign push_ok   = push_req && (!full || pop_ok);
    assign next_bit  = bit_idx_q + 3'd1;

    assign csr_data_out = csr_hit ? 32'(count_q) : 32'd0;
    assign tx           = tx_q;
    assign busy         = (state_q != IDLE);

    // FIFO storage; validity is tracked by the pointers, so no reset is needed
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Transmitter FSM; tx_q is loaded with the level of the state being entered
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            word_q     <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            cnt_q      <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (have_next) begin
                        word_q     <= mem_q[rd_ptr_q];
                        byte_idx_q <= '0;
                        cnt_q      <= prescaler;
                        tx_q       <= 1'b0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (cnt_q == 32'd0) begin
                        cnt_q     <= prescaler;
                        bit_idx_q <= '0;
                        tx_q      <= word_q[{byte_idx_q, 3'd0}];
                        state_q   <= DATA;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == 32'd0) begin
                        cnt_q <= prescaler;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= next_bit;
                            tx_q      <= word_q[{byte_idx_q, next_bit}];
                        end
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == 32'd0) begin
                        if (byte_idx_q == 2'd3) begin
                            tx_q    <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            cnt_q      <= prescaler;
                            tx_q       <= 1'b0;
                            state_q    <= START;
                        end
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam logic [2:0] OP_RW  = 3'b001;
    localparam logic [2:0] OP_RS  = 3'b010;
    localparam logic [2:0] OP_RC  = 3'b011;
    localparam logic [2:0] OP_RWI = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_enable;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic [4:0]  zimm;
    logic [31:0] rs1_data;
    logic [31:0] prescaler;
    logic [31:0] csr_data_out;
    logic        tx;
    logic        have_next;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];
    logic [31:0] fw [10];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(8), .CSR_ADDR(12'h050)) dut (
        .clk_i        (clk),
        .reset_i      (rst_n),
        .csr_enable   (csr_enable),
        .csr_addr     (csr_addr),
        .csr_op       (csr_op),
        .rs1_zimm     (zimm),
        .rs1_data     (rs1_data),
        .prescaler    (prescaler),
        .csr_data_out (csr_data_out),
        .tx           (tx),
        .have_next    (have_next),
        .busy         (busy)
    );

    // Expected tx samples for one word: one idle cycle, then four 8N1 frames
    task automatic add_word(input logic [31:0] w, input int ps);
        exp_q.push_back(1'b1);
        for (int b = 0; b < 4; b++) begin
            repeat (ps + 1) exp_q.push_back(1'b0);
            for (int k = 0; k < 8; k++) begin
                repeat (ps + 1) exp_q.push_back(w[8*b+k]);
            end
            repeat (ps + 1) exp_q.push_back(1'b1);
        end
    endtask

    task automatic add_idle(input int n);
        repeat (n) exp_q.push_back(1'b1);
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        csr_enable = 1'b1;
        csr_addr   = 12'h050;
        csr_op     = OP_RW;
        zimm       = 5'd0;
        rs1_data   = 32'hCAFEF00D;
        prescaler  = 32'd0;
        repeat (3) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
        total++; if (have_next !== 1'b0) begin bad++; $display("FAIL reset_have_next got=%b want=0", have_next); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (csr_data_out !== 32'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", csr_data_out); end
        csr_enable = 1'b0;
        rst_n      = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL post_reset_tx got=%b want=1", tx); end
        total++; if (have_next !== 1'b0) begin bad++; $display("FAIL post_reset_have_next got=%b want=0", have_next); end
    endtask

    task automatic test_back_to_back;
        exp_q.delete();
        add_word(32'h12345678, 0);
        add_word(32'hDEADBEEF, 0);
        add_word(32'h13371337, 0);
        add_idle(6);
        prescaler  = 32'd0;
        csr_enable = 1'b1;
        csr_addr   = 12'h050;
        csr_op     = OP_RW;
        rs1_data   = 32'h12345678;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                total++; if (csr_data_out !== 32'd1) begin bad++; $display("FAIL b2b_occ0 got=%0d want=1", csr_data_out); end
                rs1_data = 32'hDEADBEEF;
            end else if (i == 1) begin
                total++; if (csr_data_out !== 32'd1) begin bad++; $display("FAIL b2b_occ1 got=%0d want=1", csr_data_out); end
                rs1_data = 32'h13371337;
            end else if (i == 2) begin
                total++; if (csr_data_out !== 32'd2) begin bad++; $display("FAIL b2b_occ2 got=%0d want=2", csr_data_out); end
                csr_enable = 1'b0;
            end
            total++; if (tx !== exp_q[i]) begin bad++; $display("FAIL b2b_tx[%0d] got=%b want=%b", i, tx, exp_q[i]); end
        end
        total++; if (have_next !== 1'b0) begin bad++; $display("FAIL b2b_have_next got=%b want=0", have_next); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b want=0", busy); end
    endtask

    task automatic test_prescaler;
        exp_q.delete();
        add_word(32'h000000A5, 4);
        add_idle(5);
        prescaler  = 32'd4;
        csr_enable = 1'b1;
        csr_addr   = 12'h050;
        csr_op     = OP_RW;
        rs1_data   = 32'h000000A5;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) csr_enable = 1'b0;
            if (i == 1) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL ps_busy got=%b want=1", busy); end
            end
            total++; if (tx !== exp_q[i]) begin bad++; $display("FAIL ps_tx[%0d] got=%b want=%b", i, tx, exp_q[i]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ps_idle_busy got=%b want=0", busy); end
        prescaler = 32'd0;
    endtask

    task automatic test_fill;
        for (int k = 0; k < 10; k++) fw[k] = {8'(k), 8'hC3, 8'(k * 17), 8'h5A};
        exp_q.delete();
        for (int k = 0; k < 9; k++) add_word(fw[k], 0);
        add_idle(5);
        prescaler  = 32'd0;
        csr_enable = 1'b1;
        csr_addr   = 12'h050;
        csr_op     = OP_RW;
        rs1_data   = fw[0];
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                csr_enable = 1'b0;
            end else if (i == 1) begin
                csr_enable = 1'b1;
                rs1_data   = fw[1];
            end else if (i <= 9) begin
                total++; if (csr_data_out !== 32'(i - 1)) begin bad++; $display("FAIL fill_occ[%0d] got=%0d want=%0d", i, csr_data_out, i - 1); end
                rs1_data = fw[i];
            end else if (i == 10) begin
                total++; if (csr_data_out !== 32'd8) begin bad++; $display("FAIL fill_occ_cap got=%0d want=8", csr_data_out); end
                total++; if (have_next !== 1'b1) begin bad++; $display("FAIL fill_have_next got=%b want=1", have_next); end
                csr_enable = 1'b0;
            end
            total++; if (tx !== exp_q[i]) begin bad++; $display("FAIL fill_tx[%0d] got=%b want=%b", i, tx, exp_q[i]); end
        end
        csr_op     = OP_RS;
        csr_enable = 1'b1;
        #1;
        total++; if (csr_data_out !== 32'd0) begin bad++; $display("FAIL fill_drained_occ got=%0d want=0", csr_data_out); end
        csr_enable = 1'b0;
        total++; if (have_next !== 1'b0) begin bad++; $display("FAIL fill_drained_have_next got=%b want=0", have_next); end
    endtask

    task automatic test_imm_and_setclr;
        prescaler  = 32'd0;
        csr_enable = 1'b1;
        csr_addr   = 12'h050;
        csr_op     = OP_RS;
        rs1_data   = 32'hFFFFFFFF;
        zimm       = 5'h1F;
        @(negedge clk);
        total++; if (csr_data_out !== 32'd0) begin bad++; $display("FAIL csrrs_occ got=%0d want=0", csr_data_out); end
        csr_op = OP_RC;
        @(negedge clk);
        total++; if (csr_data_out !== 32'd0) begin bad++; $display("FAIL csrrc_occ got=%0d want=0", csr_data_out); end
        csr_op   = OP_RW;
        csr_addr = 12'h051;
        @(negedge clk);
        total++; if (have_next !== 1'b0) begin bad++; $display("FAIL other_addr_have_next got=%b want=0", have_next); end
        total++; if (csr_data_out !== 32'd0) begin bad++; $display("FAIL other_addr_read got=%0d want=0", csr_data_out); end
        exp_q.delete();
        add_word(32'h0000001F, 0);
        add_idle(5);
        csr_addr = 12'h050;
        csr_op   = OP_RWI;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                total++; if (csr_data_out !== 32'd1) begin bad++; $display("FAIL csrrwi_occ got=%0d want=1", csr_data_out); end
                csr_enable = 1'b0;
            end
            total++; if (tx !== exp_q[i]) begin bad++; $display("FAIL imm_tx[%0d] got=%b want=%b", i, tx, exp_q[i]); end
        end
        total++; if (have_next !== 1'b0) begin bad++; $display("FAIL imm_have_next got=%b want=0", have_next); end
    endtask

    task automatic test_reset_mid_frame;
        prescaler  = 32'd2;
        csr_enable = 1'b1;
        csr_addr   = 12'h050;
        csr_op     = OP_RW;
        rs1_data   = 32'h00000000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                total++; if (csr_data_out !== 32'd1) begin bad++; $display("FAIL mid_occ0 got=%0d want=1", csr_data_out); end
                rs1_data = 32'hFFFFFFFF;
            end else if (i == 1) begin
                total++; if (csr_data_out !== 32'd1) begin bad++; $display("FAIL mid_occ1 got=%0d want=1", csr_data_out); end
                rs1_data = 32'h12345678;
            end else if (i == 2) begin
                total++; if (csr_data_out !== 32'd2) begin bad++; $display("FAIL mid_occ2 got=%0d want=2", csr_data_out); end
                csr_enable = 1'b0;
            end
        end
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_data_tx got=%b want=0", tx); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_data_busy got=%b want=1", busy); end
        total++; if (have_next !== 1'b1) begin bad++; $display("FAIL mid_data_have_next got=%b want=1", have_next); end
        rst_n = 1'b0;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_reset_tx got=%b want=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
        total++; if (have_next !== 1'b0) begin bad++; $display("FAIL mid_reset_have_next got=%b want=0", have_next); end
        csr_op     = OP_RS;
        csr_enable = 1'b1;
        #1;
        total++; if (csr_data_out !== 32'd0) begin bad++; $display("FAIL mid_reset_occ got=%0d want=0", csr_data_out); end
        csr_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++; if (tx !== 1'b1) begin bad++; $display("FAIL post_abort_tx[%0d] got=%b want=1", i, tx); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_abort_busy got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_prescaler();
        test_fill();
        test_imm_and_setclr();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
